// File: rtl/cache_pkg.sv
// Shared types for the direct-mapped write-back data cache.
// Also holds the LSU/DRAM operation encoding and the line record.
package cache_pkg;

    localparam int TAG_W     = 6;
    localparam int DATA_W    = 32;
    localparam int NUM_LINES = 16;

    typedef enum logic {
        LW = 1'b0,
        SW = 1'b1
    } lsu_ops;

    typedef enum logic [2:0] {
        IDLE,
        COMPARE,
        WRITEBACK,
        REFILL_REQ,
        REFILL_WAIT,
        RESPOND
    } dc_state_e;

    typedef struct packed {
        logic              valid;
        logic              dirty;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } cache_line_t;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/dc_line_array.sv
// Line storage: valid/dirty bits are reset, tag/data are not.
// One combinational read port and one full-line write port.
module dc_line_array
    import cache_pkg::*;
#(
    parameter int  NUM_LINES = 16,
    parameter int  IDX_W     = $clog2(NUM_LINES),
    parameter type line_t    = cache_line_t
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx,
    output line_t            rd_line,
    input  logic             we,
    input  logic [IDX_W-1:0] wr_idx,
    input  line_t            wr_line
);

    logic [NUM_LINES-1:0] valid_q, valid_d;
    logic [NUM_LINES-1:0] dirty_q, dirty_d;
    line_t                mem_q [NUM_LINES];

    always_comb begin
        valid_d = valid_q;
        dirty_d = dirty_q;
        if (we) begin
            valid_d[wr_idx] = wr_line.valid;
            dirty_d[wr_idx] = wr_line.dirty;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            valid_q <= valid_d;
            dirty_q <= dirty_d;
        end
    end

    // Tag and data carry no reset; the valid bit guards them.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[wr_idx] <= wr_line;
        end
    end

    always_comb begin
        rd_line       = mem_q[rd_idx];
        rd_line.valid = valid_q[rd_idx];
        rd_line.dirty = dirty_q[rd_idx];
    end

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped write-back, write-allocate data cache controller.
// Hits resolve locally; misses write back a dirty victim then refill.
module dcache_controller
    import cache_pkg::*;
#(
    parameter int TAG       = 6,
    parameter int DATA      = 32,
    parameter int NUM_LINES = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  lsu_ops            cpu_op,
    input  logic [31:0]       cpu_addr,
    input  logic [DATA-1:0]   cpu_wdata,
    output logic              cpu_ready,
    output logic              cpu_rsp_valid,
    output logic [DATA-1:0]   cpu_rdata,
    output logic              mem_req,
    output lsu_ops            lsu_operator,
    output logic [31:0]       address,
    output logic [TAG+DATA:0] write_data_int,
    input  logic              mem_ready,
    input  logic [DATA-1:0]   dram_data_out,
    output logic [15:0]       hit_count,
    output logic [15:0]       miss_count
);

    localparam int IDX_W = $clog2(NUM_LINES);

    typedef struct packed {
        logic            valid;
        logic            dirty;
        logic [TAG-1:0]  tag;
        logic [DATA-1:0] data;
    } line_t;

    dc_state_e        state_q, state_d;
    lsu_ops           op_q, op_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [TAG-1:0]   tag_q, tag_d;
    logic [DATA-1:0]  wdata_q, wdata_d;
    logic [DATA-1:0]  rdata_q, rdata_d;
    logic [15:0]      hit_q, hit_d;
    logic [15:0]      miss_q, miss_d;

    line_t rd_line, wr_line;
    logic  we;
    logic  hit;
    logic  unused_addr_hi;

    assign unused_addr_hi = ^cpu_addr[31:IDX_W+TAG];

    dc_line_array #(
        .NUM_LINES (NUM_LINES),
        .IDX_W     (IDX_W),
        .line_t    (line_t)
    ) u_lines (
        .clk     (clk),
        .rst     (rst),
        .rd_idx  (idx_q),
        .rd_line (rd_line),
        .we      (we),
        .wr_idx  (idx_q),
        .wr_line (wr_line)
    );

    assign hit        = rd_line.valid && (rd_line.tag == tag_q);
    assign cpu_rdata  = rdata_q;
    assign hit_count  = hit_q;
    assign miss_count = miss_q;

    // DRAM-side outputs depend only on state and latched request.
    always_comb begin
        state_d        = state_q;
        op_d           = op_q;
        idx_d          = idx_q;
        tag_d          = tag_q;
        wdata_d        = wdata_q;
        rdata_d        = rdata_q;
        hit_d          = hit_q;
        miss_d         = miss_q;
        we             = 1'b0;
        wr_line        = rd_line;
        cpu_ready      = 1'b0;
        cpu_rsp_valid  = 1'b0;
        mem_req        = 1'b0;
        lsu_operator   = LW;
        address        = '0;
        write_data_int = '0;
        unique case (state_q)
            IDLE: begin
                cpu_ready = 1'b1;
                if (cpu_req) begin
                    op_d    = cpu_op;
                    idx_d   = cpu_addr[IDX_W-1:0];
                    tag_d   = cpu_addr[IDX_W+TAG-1:IDX_W];
                    wdata_d = cpu_wdata;
                    state_d = COMPARE;
                end
            end
            COMPARE: begin
                if (hit) begin
                    hit_d   = sat_inc(hit_q);
                    state_d = RESPOND;
                    if (op_q == SW) begin
                        we            = 1'b1;
                        wr_line.data  = wdata_q;
                        wr_line.dirty = 1'b1;
                    end else begin
                        rdata_d = rd_line.data;
                    end
                end else begin
                    miss_d  = sat_inc(miss_q);
                    state_d = (rd_line.valid && rd_line.dirty)
                            ? WRITEBACK : REFILL_REQ;
                end
            end
            WRITEBACK: begin
                mem_req        = 1'b1;
                lsu_operator   = SW;
                address        = 32'({rd_line.tag, idx_q});
                write_data_int = {1'b1, rd_line.tag, rd_line.data};
                if (mem_ready) begin
                    state_d = REFILL_REQ;
                end
            end
            REFILL_REQ: begin
                mem_req      = 1'b1;
                lsu_operator = LW;
                address      = 32'({tag_q, idx_q});
                if (mem_ready) begin
                    state_d = REFILL_WAIT;
                end
            end
            REFILL_WAIT: begin
                we            = 1'b1;
                wr_line.valid = 1'b1;
                wr_line.tag   = tag_q;
                if (op_q == SW) begin
                    wr_line.data  = wdata_q;
                    wr_line.dirty = 1'b1;
                end else begin
                    wr_line.data  = dram_data_out;
                    wr_line.dirty = 1'b0;
                    rdata_d       = dram_data_out;
                end
                state_d = RESPOND;
            end
            RESPOND: begin
                cpu_rsp_valid = 1'b1;
                state_d       = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= LW;
            idx_q   <= '0;
            tag_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            hit_q   <= '0;
            miss_q  <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            idx_q   <= idx_d;
            tag_q   <= tag_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            hit_q   <= hit_d;
            miss_q  <= miss_d;
        end
    end

endmodule

// File: tb/tb_dcache_controller.sv
// Self-checking bench for dcache_controller with a DRAM stub
// and an array-based reference model of the cache.
module tb_dcache_controller;
    import cache_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req;
    lsu_ops      cpu_op;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_ready;
    logic        cpu_rsp_valid;
    logic [31:0] cpu_rdata;
    logic        mem_req;
    lsu_ops      lsu_operator;
    logic [31:0] address;
    logic [38:0] write_data_int;
    logic        mem_ready;
    logic [31:0] dram_data_out = 32'h0;
    logic [15:0] hit_count;
    logic [15:0] miss_count;

    int n_pass = 0;
    int n_chk  = 0;
    logic stall = 1'b0;

    always #5 clk = ~clk;

    dcache_controller #(.TAG(6), .DATA(32), .NUM_LINES(16)) dut (
        .clk            (clk),
        .rst            (rst),
        .cpu_req        (cpu_req),
        .cpu_op         (cpu_op),
        .cpu_addr       (cpu_addr),
        .cpu_wdata      (cpu_wdata),
        .cpu_ready      (cpu_ready),
        .cpu_rsp_valid  (cpu_rsp_valid),
        .cpu_rdata      (cpu_rdata),
        .mem_req        (mem_req),
        .lsu_operator   (lsu_operator),
        .address        (address),
        .write_data_int (write_data_int),
        .mem_ready      (mem_ready),
        .dram_data_out  (dram_data_out),
        .hit_count      (hit_count),
        .miss_count     (miss_count)
    );

    // DRAM stub: untouched words read as 0xDEAD0000 | address.
    logic [31:0] dmem [int unsigned];
    assign mem_ready = mem_req && !stall;

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return 32'hDEAD0000 | {16'h0, a[15:0]};
    endfunction

    always @(posedge clk) begin
        if (mem_req && mem_ready) begin
            if (lsu_operator == LW)
                dram_data_out <= dmem.exists(address) ? dmem[address] : dflt(address);
            else
                dmem[address] = write_data_int[31:0];
        end
    end

    // Reference model
    bit          m_valid [16];
    bit          m_dirty [16];
    int          m_tag   [16];
    logic [31:0] m_data  [16];
    logic [31:0] m_mem   [int unsigned];
    int          m_hits, m_miss;
    logic [31:0] m_rdata;

    function automatic void model_reset();
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 0;
            m_dirty[i] = 0;
        end
        m_hits  = 0;
        m_miss  = 0;
        m_rdata = 0;
    endfunction

    function automatic void model_access(input lsu_ops op, input logic [31:0] a,
                                         input logic [31:0] wd,
                                         output int lat, output bit wb);
        int idx = int'(a % 16);
        int tg  = int'((a / 16) % 64);
        int unsigned key;
        wb = 0;
        if (m_valid[idx] && m_tag[idx] == tg) begin
            if (m_hits < 65535) m_hits++;
            lat = 2;
        end else begin
            if (m_miss < 65535) m_miss++;
            if (m_valid[idx] && m_dirty[idx]) begin
                wb = 1;
                m_mem[m_tag[idx] * 16 + idx] = m_data[idx];
            end
            lat = wb ? 5 : 4;
            key = tg * 16 + idx;
            m_valid[idx] = 1;
            m_dirty[idx] = 0;
            m_tag[idx]   = tg;
            m_data[idx]  = m_mem.exists(key) ? m_mem[key] : dflt(key);
        end
        if (op == SW) begin
            m_data[idx]  = wd;
            m_dirty[idx] = 1;
        end else begin
            m_rdata = m_data[idx];
        end
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic do_req(input lsu_ops op, input logic [31:0] a, input logic [31:0] wd,
                          output int lat, output bit wb_seen,
                          output logic [31:0] wb_addr, output logic [38:0] wb_wdi,
                          output logic [31:0] rf_addr);
        int g = 0;
        @(negedge clk);
        while (!cpu_ready && g < 20) begin
            @(negedge clk);
            g++;
        end
        cpu_req   = 1'b1;
        cpu_op    = op;
        cpu_addr  = a;
        cpu_wdata = wd;
        @(posedge clk);
        #1 cpu_req = 1'b0;
        lat = 0; wb_seen = 0; wb_addr = '1; wb_wdi = '1; rf_addr = '1;
        while (lat < 30) begin
            @(negedge clk);
            lat++;
            if (mem_req && lsu_operator == SW) begin
                wb_seen = 1;
                wb_addr = address;
                wb_wdi  = write_data_int;
            end
            if (mem_req && lsu_operator == LW) rf_addr = address;
            if (cpu_rsp_valid) break;
        end
    endtask

    task automatic mreq(input string nm, input lsu_ops op, input logic [31:0] a,
                        input logic [31:0] wd);
        int lat, elat;
        bit wbs, ewb;
        logic [31:0] wa, ra;
        logic [38:0] wdi;
        model_access(op, a, wd, elat, ewb);
        do_req(op, a, wd, lat, wbs, wa, wdi, ra);
        chk({nm, ".lat"}, 64'(lat), 64'(elat));
        chk({nm, ".wb"}, 64'(wbs), 64'(ewb));
        chk({nm, ".rdata"}, 64'(cpu_rdata), 64'(m_rdata));
        chk({nm, ".hits"}, 64'(hit_count), 64'(m_hits));
        chk({nm, ".miss"}, 64'(miss_count), 64'(m_miss));
    endtask

    typedef struct {
        lsu_ops      op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        int          exp_lat;
        bit          exp_wb;
        int          exp_hits;
        int          exp_miss;
    } vec_t;

    vec_t vt [5];

    initial begin
        int lat, elat, cnt, acc, rsps;
        bit wbs, ewb;
        logic [31:0] wa, ra;
        logic [38:0] wdi;
        logic [31:0] q [$];

        vt[0] = '{LW, 32'h005, 32'h0,        32'hDEAD0005, 4, 0, 0, 1};
        vt[1] = '{LW, 32'h005, 32'h0,        32'hDEAD0005, 2, 0, 1, 1};
        vt[2] = '{SW, 32'h005, 32'h12345678, 32'hDEAD0005, 2, 0, 2, 1};
        vt[3] = '{LW, 32'h015, 32'h0,        32'hDEAD0015, 5, 1, 2, 2};
        vt[4] = '{LW, 32'h005, 32'h0,        32'h12345678, 4, 0, 2, 3};

        rst = 1'b1; cpu_req = 1'b0; cpu_op = LW; cpu_addr = '0; cpu_wdata = '0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst.ready", 64'(cpu_ready), 64'd1);
        chk("rst.rsp", 64'(cpu_rsp_valid), 64'd0);
        chk("rst.rdata", 64'(cpu_rdata), 64'd0);
        chk("rst.hits", 64'(hit_count), 64'd0);
        chk("rst.miss", 64'(miss_count), 64'd0);
        chk("rst.mem_req", 64'(mem_req), 64'd0);
        chk("rst.op", 64'(lsu_operator), 64'(LW));
        chk("rst.addr", 64'(address), 64'd0);
        chk("rst.wdi", 64'(write_data_int), 64'd0);

        for (int i = 0; i < 5; i++) begin
            model_access(vt[i].op, vt[i].addr, vt[i].wdata, elat, ewb);
            do_req(vt[i].op, vt[i].addr, vt[i].wdata, lat, wbs, wa, wdi, ra);
            chk($sformatf("vec%0d.lat", i), 64'(lat), 64'(vt[i].exp_lat));
            chk($sformatf("vec%0d.wb", i), 64'(wbs), 64'(vt[i].exp_wb));
            chk($sformatf("vec%0d.rdata", i), 64'(cpu_rdata), 64'(vt[i].exp_rdata));
            chk($sformatf("vec%0d.hits", i), 64'(hit_count), 64'(vt[i].exp_hits));
            chk($sformatf("vec%0d.miss", i), 64'(miss_count), 64'(vt[i].exp_miss));
            if (i == 0) chk("cold.rf_addr", 64'(ra), 64'h005);
            if (i == 3) begin
                chk("wb.addr", 64'(wa), 64'h005);
                chk("wb.data", 64'(wdi[31:0]), 64'h12345678);
                chk("wb.tag", 64'(wdi[38:32]), 64'h40);
                chk("evict.rf_addr", 64'(ra), 64'h015);
            end
        end

        // Reset while a refill request is stalled
        stall = 1'b1;
        @(negedge clk);
        cpu_req = 1'b1; cpu_op = LW; cpu_addr = 32'h025;
        @(posedge clk);
        #1 cpu_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("stall.mem_req", 64'(mem_req), 64'd1);
        chk("stall.addr", 64'(address), 64'h025);
        #2 rst = 1'b1;
        #1;
        chk("arst.mem_req", 64'(mem_req), 64'd0);
        chk("arst.ready", 64'(cpu_ready), 64'd1);
        chk("arst.hits", 64'(hit_count), 64'd0);
        chk("arst.miss", 64'(miss_count), 64'd0);
        model_reset();
        cnt = 0;
        repeat (2) begin
            @(negedge clk);
            if (cpu_rsp_valid) cnt++;
        end
        rst = 1'b0;
        stall = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (cpu_rsp_valid) cnt++;
        end
        chk("arst.no_rsp", 64'(cnt), 64'd0);
        chk("arst.rdata", 64'(cpu_rdata), 64'd0);
        mreq("post_rst", LW, 32'h005, 32'h0);
        chk("post_rst.val", 64'(cpu_rdata), 64'h12345678);

        // cpu_req held high across several requests
        acc = 0; rsps = 0; cnt = 0;
        @(negedge clk);
        cpu_req = 1'b1;
        while (acc < 3 && cnt < 60) begin
            if (cpu_rsp_valid) begin
                rsps++;
                chk("b2b.rdata", 64'(cpu_rdata), 64'(q.pop_front()));
            end
            cpu_op   = LW;
            cpu_addr = 32'((cnt * 7) % 64);
            if (cpu_ready) begin
                acc++;
                model_access(LW, cpu_addr, 32'h0, elat, ewb);
                q.push_back(m_rdata);
            end
            @(negedge clk);
            cnt++;
        end
        cpu_req = 1'b0;
        repeat (12) begin
            if (cpu_rsp_valid) begin
                rsps++;
                if (q.size() > 0) chk("b2b.rdata", 64'(cpu_rdata), 64'(q.pop_front()));
            end
            @(negedge clk);
        end
        chk("b2b.accepted", 64'(acc), 64'd3);
        chk("b2b.rsps", 64'(rsps), 64'd3);
        chk("b2b.hits", 64'(hit_count), 64'(m_hits));
        chk("b2b.miss", 64'(miss_count), 64'(m_miss));

        // Randomized traffic against the model
        for (int i = 0; i < 150; i++) begin
            logic [31:0] a;
            lsu_ops op;
            a  = ($urandom & 32'hFFFF_FC00) | 32'($urandom_range(0, 3) * 16)
               | 32'($urandom_range(0, 15));
            op = ($urandom_range(0, 1) == 1) ? SW : LW;
            mreq($sformatf("rnd%0d", i), op, a, $urandom);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/dcache_controller.md
Name: dcache_controller

Overview:
- Direct-mapped, write-back, write-allocate data-cache controller; one 32-bit word per line.
- Sits between the LSU and the dummy_dram backing store.
- Accepts LSU load/store requests and resolves hits locally.
- On a miss, writes back the dirty victim, then refills the line, driving dummy_dram's mem_req/lsu_operator/address/write_data_int handshake.

Parameters:
- TAG, 6, tag width in bits.
- DATA, 32, data word width.
- NUM_LINES, 16, number of cache lines; power of 2. IDX_W = log2(NUM_LINES); TAG+IDX_W <= 32.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- cpu_req  in  1  LSU request strobe; sampled only while cpu_ready=1.
- cpu_op  in  lsu_ops  LW or SW.
- cpu_addr  in  32  word address; index = [IDX_W-1:0], tag = [IDX_W+TAG-1:IDX_W], upper bits ignored.
- cpu_wdata  in  DATA  store data.
- cpu_ready  out  1  controller idle, can accept a request.
- cpu_rsp_valid  out  1  one-cycle completion pulse.
- cpu_rdata  out  DATA  load result; valid with cpu_rsp_valid.
- mem_req  out  1  DRAM request.
- lsu_operator  out  lsu_ops  DRAM operation.
- address  out  32  DRAM word address = zero-extended {tag, index}.
- write_data_int  out  TAG+DATA+1  {1'b1, victim tag, victim data}.
- mem_ready  in  1  DRAM accepted the request this cycle.
- dram_data_out  in  DATA  DRAM read data; registered, valid the cycle after an accepted LW.
- hit_count  out  16  saturating hit counter.
- miss_count  out  16  saturating miss counter.

Behaviour:
- Reset (async) sets:
  - state to IDLE; all valid/dirty bits to 0;
  - cpu_rsp_valid=0, cpu_rdata=0, hit_count=0, miss_count=0;
  - mem_req=0, lsu_operator=LW, address=0, write_data_int=0.
  - Tag/data arrays are not cleared.
- DRAM-side outputs decode from the state and latched request only; no combinational path from cpu_* inputs.
- IDLE: cpu_ready=1. On cpu_req, latch op/addr/wdata, go to COMPARE. cpu_req while cpu_ready=0 is ignored (no queueing).
- COMPARE: hit = valid[idx] && tag[idx]==req_tag.
  - Hit LW: cpu_rdata <= line data; hit_count++; go to RESPOND.
  - Hit SW: line data <= wdata; dirty=1; hit_count++; go to RESPOND.
  - Miss: miss_count++. If valid && dirty, go to WRITEBACK; else go to REFILL_REQ.
- WRITEBACK: mem_req=1, lsu_operator=SW, address={victim tag, idx}, write_data_int={1'b1, victim tag, victim data}. Hold until mem_ready=1, then go to REFILL_REQ.
- REFILL_REQ: mem_req=1, lsu_operator=LW, address={req_tag, idx}. Hold until mem_ready, then go to REFILL_WAIT.
- REFILL_WAIT: mem_req=0. Install valid=1, tag=req_tag.
  - LW: data=dram_data_out, dirty=0, cpu_rdata<=dram_data_out.
  - SW: data=wdata, dirty=1.
  - Go to RESPOND.
- RESPOND: cpu_rsp_valid=1 for exactly one cycle, then IDLE. cpu_rdata holds its value until the next load response. SW responses leave cpu_rdata unchanged.
- Latency, counted from the edge sampling cpu_req to the rsp_valid cycle: hit 2, clean miss 4, dirty miss 5 (with the combinational mem_ready).
- Counters saturate at 16'hFFFF; no wrap.
- Reset mid-operation: immediate return to IDLE; mem_req deasserts asynchronously; no response is issued. A DRAM write not yet clocked is lost.
- Index aliasing: addresses differing only in tag bits evict each other.

Decomposition:
- cache_pkg: reuse lsu_ops; add dc_state_e {IDLE, COMPARE, WRITEBACK, REFILL_REQ, REFILL_WAIT, RESPOND} and a cache_line_t struct {valid, dirty, tag, data}.
- Sub-module dc_line_array: NUM_LINES registers.
  - Async reset clears valid/dirty.
  - One combinational read port by index.
  - One synchronous write port with full-line write enable.
- Controller FSM and counters stay in dcache_controller.

Test Plan:
- Cold LW 0x005 -> REFILL_REQ with address=0x005, LW; rsp 4 cycles later; cpu_rdata=0xDEAD0005; miss_count=1.
- Repeat LW 0x005 -> no mem_req; rsp after 2 cycles; cpu_rdata=0xDEAD0005; hit_count=1.
- SW 0x005 data 0x12345678, then LW 0x015 (same index, tag 1):
  - WRITEBACK: mem_req=1, SW, address=0x005, write_data_int low 32 bits = 0x12345678.
  - Refill from 0x015; rdata=0xDEAD0015; 5-cycle latency.
- LW 0x005 after the previous case -> clean miss (no WRITEBACK state); rdata=0x12345678, proving the DRAM write landed.
- Assert rst during REFILL_REQ -> mem_req=0 immediately; state IDLE; counters 0; no cpu_rsp_valid; next LW 0x005 misses.
- Hold cpu_req high for 3 back-to-back requests -> only the request sampled in IDLE is serviced; exactly one rsp pulse per accepted request.
